// File: rtl/image_cell_sequencer_pkg.sv
// Shared types for the image cell sequencer: pixel/operand widths, cell packing and FSM states.
package image_cell_sequencer_pkg;

    localparam int unsigned PIXEL_WIDTH  = 8;
    localparam int unsigned OPCODE_WIDTH = 4;
    localparam int unsigned USER_WIDTH   = 8;
    localparam int unsigned CELL_PIXELS  = 9;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;
    typedef logic [USER_WIDTH-1:0]  user_input_t;

    localparam int unsigned CELL_DEPTH = CELL_PIXELS * $bits(pixel_t);

    typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} seq_state_t;

    typedef struct packed {
        logic   last;
        pixel_t pixel;
    } result_t;

    // Columns are packed top row first; cell index is k = 3*row + col.
    function automatic logic [CELL_DEPTH-1:0] pack_cell(
        input logic [3*PIXEL_WIDTH-1:0] left,
        input logic [3*PIXEL_WIDTH-1:0] mid,
        input logic [3*PIXEL_WIDTH-1:0] right
    );
        logic [3*PIXEL_WIDTH-1:0] cols [3];
        pack_cell = '0;
        cols[0]   = left;
        cols[1]   = mid;
        cols[2]   = right;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                pack_cell[(3*r+c)*PIXEL_WIDTH +: PIXEL_WIDTH] = cols[c][r*PIXEL_WIDTH +: PIXEL_WIDTH];
            end
        end
    endfunction

endpackage

// File: rtl/cell_result_fifo.sv
// Synchronous result FIFO; read data reads as zero while empty.
module cell_result_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 9
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           rdata_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign do_push = push_i && (count_q != CW'(Depth));
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_cell_sequencer.sv
// Streams two raster images through 3x3 windows into the cell processor and collects results.
// Optional statistics counters are built when CELL_SEQ_STATS_EN is defined.
module image_cell_sequencer
    import image_cell_sequencer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH      = 64,
    parameter int unsigned IMG_HEIGHT     = 64,
    parameter int unsigned PROC_LAT       = 1,
    parameter int unsigned OUT_FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OPCODE_WIDTH-1:0] opcode_in,
    input  logic [USER_WIDTH-1:0]   user_in,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIXEL_WIDTH-1:0]  in_pixA,
    input  logic [PIXEL_WIDTH-1:0]  in_pixB,
    output logic [CELL_DEPTH-1:0]   cellA,
    output logic [CELL_DEPTH-1:0]   cellB,
    output logic [USER_WIDTH-1:0]   userInputA,
    output logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [PIXEL_WIDTH-1:0]  processedPixel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIXEL_WIDTH-1:0]  out_pixel,
`ifdef CELL_SEQ_STATS_EN
    output logic [31:0]             stat_pixels,
    output logic [31:0]             stat_stalls,
`endif
    output logic                    out_last
);

    localparam int unsigned CW   = $clog2(IMG_WIDTH);
    localparam int unsigned RW   = $clog2(IMG_HEIGHT);
    localparam int unsigned CNTW = $clog2(OUT_FIFO_DEPTH + 1);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] TWO_COL  = CW'(2);
    localparam logic [RW-1:0] TWO_ROW  = RW'(2);

    seq_state_t              state_q;
    logic                    busy_q, done_q;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [USER_WIDTH-1:0]   user_q;
    logic [CW-1:0]           col_q;
    logic [RW-1:0]           row_q;
    logic                    active, accept, issue, last_px;
    logic [31:0]             credit;
    logic [CNTW-1:0]         fifo_count;
    logic                    fifo_empty, fifo_pop;
    result_t                 fifo_rdata;
    logic [PROC_LAT:0]       pipe_q, pipe_d, last_pipe_q, last_pipe_d;

    logic [PIXEL_WIDTH-1:0]   lb1_a_q [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0]   lb2_a_q [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0]   lb1_b_q [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0]   lb2_b_q [IMG_WIDTH];
    logic [3*PIXEL_WIDTH-1:0] win_a_q [2];
    logic [3*PIXEL_WIDTH-1:0] win_b_q [2];
    logic [3*PIXEL_WIDTH-1:0] new_col_a, new_col_b;
    logic [CELL_DEPTH-1:0]    cell_a_q, cell_b_q;

    // Credit counts results already issued, so the FIFO can never be overrun.
    assign active   = (state_q == FILL) || (state_q == RUN);
    assign credit   = 32'(fifo_count) + 32'($countones(pipe_q));
    assign in_ready = active && (credit < OUT_FIFO_DEPTH);
    assign accept   = in_valid && in_ready;
    assign last_px  = (row_q == LAST_ROW) && (col_q == LAST_COL);
    assign issue    = accept && (row_q >= TWO_ROW) && (col_q >= TWO_COL);

    assign new_col_a = {in_pixA, lb1_a_q[col_q], lb2_a_q[col_q]};
    assign new_col_b = {in_pixB, lb1_b_q[col_q], lb2_b_q[col_q]};

    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_a_q[col_q] <= lb1_a_q[col_q];
            lb1_a_q[col_q] <= in_pixA;
            lb2_b_q[col_q] <= lb1_b_q[col_q];
            lb1_b_q[col_q] <= in_pixB;
            win_a_q[0]     <= win_a_q[1];
            win_a_q[1]     <= new_col_a;
            win_b_q[0]     <= win_b_q[1];
            win_b_q[1]     <= new_col_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_a_q <= '0;
            cell_b_q <= '0;
        end else if (issue) begin
            cell_a_q <= pack_cell(win_a_q[0], win_a_q[1], new_col_a);
            cell_b_q <= pack_cell(win_b_q[0], win_b_q[1], new_col_b);
        end
    end

    always_comb begin
        pipe_d         = '0;
        last_pipe_d    = '0;
        pipe_d[0]      = issue;
        last_pipe_d[0] = issue && last_px;
        for (int unsigned i = 1; i <= PROC_LAT; i++) begin
            pipe_d[i]      = pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q      <= '0;
            last_pipe_q <= '0;
        end else begin
            pipe_q      <= pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            opcode_q <= '0;
            user_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    col_q <= '0;
                    row_q <= '0;
                    if (start) begin
                        state_q  <= FILL;
                        busy_q   <= 1'b1;
                        opcode_q <= opcode_in;
                        user_q   <= user_in;
                    end
                end
                FILL, RUN: begin
                    if (accept) begin
                        // A 3x3 image completes on its first window, so last pixel wins.
                        if (last_px) begin
                            state_q <= DRAIN;
                        end else if (row_q == TWO_ROW && col_q == TWO_COL) begin
                            state_q <= RUN;
                        end
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            row_q <= last_px ? '0 : row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_q == '0 && fifo_empty) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_pop = !fifo_empty && out_ready;

    cell_result_fifo #(
        .Depth (OUT_FIFO_DEPTH),
        .Width ($bits(result_t))
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (pipe_q[PROC_LAT]),
        .wdata_i ({last_pipe_q[PROC_LAT], processedPixel}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign busy       = busy_q;
    assign done       = done_q;
    assign cellA      = cell_a_q;
    assign cellB      = cell_b_q;
    assign opcode     = opcode_q;
    assign userInputA = user_q;
    assign out_valid  = !fifo_empty;
    assign out_pixel  = fifo_rdata.pixel;
    assign out_last   = fifo_rdata.last;

`ifdef CELL_SEQ_STATS_EN
    logic [31:0] stat_pixels_q, stat_stalls_q;

    // Only an accepted start clears; a start ignored mid-frame leaves the counts alone.
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start)) begin
            stat_pixels_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (fifo_pop && stat_pixels_q != '1) begin
                stat_pixels_q <= stat_pixels_q + 1'b1;
            end
            if (active && in_valid && !in_ready && stat_stalls_q != '1) begin
                stat_stalls_q <= stat_stalls_q + 1'b1;
            end
        end
    end

    assign stat_pixels = stat_pixels_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_image_cell_sequencer.sv
// Scoreboard bench for image_cell_sequencer on a 4x4 image with a 2-cycle processor model.
module tb_image_cell_sequencer;
    import image_cell_sequencer_pkg::*;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 3;
    localparam int NPIX  = W * H;

    typedef struct {
        logic [7:0] pix;
        logic       last;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [OPCODE_WIDTH-1:0] opcode_in = '0;
    logic [USER_WIDTH-1:0]   user_in = '0;
    logic                    busy, done, in_ready, out_valid, out_last;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic [7:0]              in_pixA = '0, in_pixB = '0;
    logic [CELL_DEPTH-1:0]   cellA, cellB;
    logic [USER_WIDTH-1:0]   userInputA;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [7:0]              processedPixel, out_pixel;
`ifdef CELL_SEQ_STATS_EN
    logic [31:0]             stat_pixels, stat_stalls;
`endif

    int   checks = 0, failures = 0;
    int   done_cnt = 0, pop_total = 0, outstanding = 0, rdy_mode = 1;
    logic issue_pend = 1'b0, pop_pend = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    image_cell_sequencer #(
        .IMG_WIDTH      (W),
        .IMG_HEIGHT     (H),
        .PROC_LAT       (LAT),
        .OUT_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .opcode_in      (opcode_in),
        .user_in        (user_in),
        .busy           (busy),
        .done           (done),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pixA        (in_pixA),
        .in_pixB        (in_pixB),
        .cellA          (cellA),
        .cellB          (cellB),
        .userInputA     (userInputA),
        .opcode         (opcode),
        .processedPixel (processedPixel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pixel      (out_pixel),
`ifdef CELL_SEQ_STATS_EN
        .stat_pixels    (stat_pixels),
        .stat_stalls    (stat_stalls),
`endif
        .out_last       (out_last)
    );

    // Processor model: A[sel] + B[8-sel] + opcode, sel = userInputA mod 9, LAT cycles late.
    logic [7:0] proc_now, pd1, pd2;
    always_comb begin
        int sel;
        sel      = int'(userInputA) % 9;
        proc_now = cellA[sel*8 +: 8] + cellB[(8-sel)*8 +: 8] + 8'(opcode);
    end
    always @(posedge clk) begin
        pd1 <= proc_now;
        pd2 <= pd1;
    end
    assign processedPixel = pd2;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Results issued but not yet popped, tracked from handshakes seen on the previous negedge.
    always @(posedge clk) begin
        if (rst) outstanding <= 0;
        else     outstanding <= outstanding + int'(issue_pend) - int'(pop_pend);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold stability.
    logic       hold_v = 1'b0, hold_last = 1'b0;
    logic [7:0] hold_pix = '0;
    always @(negedge clk) begin
        exp_t e;
        pop_pend = 1'b0;
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("out_hold", {out_valid, out_last, out_pixel}, {1'b1, hold_last, hold_pix});
            end
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                pop_pend = 1'b1;
                pop_total++;
                if (exp_q.size() == 0) begin
                    check("out_unexpected", 64'(out_pixel), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pixel", 64'(out_pixel), 64'(e.pix));
                    check("out_last", 64'(out_last), 64'(e.last));
                end
            end
            hold_v    = out_valid && !out_ready;
            hold_pix  = out_pixel;
            hold_last = out_last;
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_in_ready"}, 64'(in_ready), 0);
        check({tag, "_out"}, {61'd0, out_valid, out_last, |out_pixel}, 0);
        check({tag, "_cells"}, {62'd0, |cellA, |cellB}, 0);
        check({tag, "_latched"}, {52'd0, opcode, userInputA}, 0);
    endtask

    // pat 0: A = raster index, B = 0; pat 1: random. rmode 0 holds out_ready low until stalls.
    task automatic run_frame(input int pat, input logic [3:0] op, input logic [7:0] usr,
                             input int gap, input int rmode, input int abort_at,
                             input bit mid_start);
        logic [7:0] a[NPIX], b[NPIX];
        int idx, cyc, stalls, pops0, done0, k, kb;
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            a[i] = (pat == 0) ? 8'(i) : 8'($urandom);
            b[i] = (pat == 0) ? 8'd0 : 8'($urandom);
        end
        k  = int'(usr) % 9;
        kb = 8 - k;
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                e.pix  = a[(r-2+k/3)*W + c-2+k%3] + b[(r-2+kb/3)*W + c-2+kb%3] + 8'(op);
                e.last = (r == H-1) && (c == W-1);
                exp_q.push_back(e);
            end
        end
        rdy_mode  = rmode;
        stalls    = 0;
        pops0     = pop_total;
        done0     = done_cnt;
        start     = 1'b1;
        opcode_in = op;
        user_in   = usr;
        tick();
        start = 1'b0;
        idx   = 0;
        cyc   = 0;
        while (idx < NPIX && cyc < 500) begin
            in_valid  = (gap == 0) || ($urandom_range(0, 2) != 0);
            in_pixA   = a[idx];
            in_pixB   = b[idx];
            opcode_in = 4'($urandom);
            user_in   = 8'($urandom);
            if (mid_start && idx == 11) start = 1'b1;
            @(negedge clk);
            check("in_ready", 64'(in_ready), 64'(outstanding < DEPTH));
            check("busy_frame", 64'(busy), 1);
            check("latched", {52'd0, opcode, userInputA}, {52'd0, op, usr});
            if (in_valid && !in_ready) stalls++;
            if (rmode == 0 && stalls >= 5) rdy_mode = 1;
            if (in_valid && in_ready) begin
                issue_pend = (idx / W >= 2) && (idx % W >= 2);
                idx++;
            end
            tick();
            issue_pend = 1'b0;
            start      = 1'b0;
            cyc++;
            if (abort_at > 0 && idx == abort_at) begin
                in_valid = 1'b0;
                rst      = 1'b1;
                tick();
                rst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                check_idle("abort");
                repeat (4) @(negedge clk);
                check("abort_no_done", 64'(done_cnt - done0), 0);
                return;
            end
        end
        in_valid = 1'b0;
        if (idx < NPIX) check("feed_timeout", 64'(idx), 64'(NPIX));
        if (rmode == 0) check("backpressure_stall", 64'(stalls >= 5), 1);
        rdy_mode = (rmode == 2) ? 2 : 1;
        cyc = 0;
        while (done_cnt == done0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(done_cnt - done0), 1);
        check("scoreboard_empty", 64'(exp_q.size()), 0);
        check("results_popped", 64'(pop_total - pops0), 64'((W-2)*(H-2)));
        check("idle_after_done", {62'd0, busy, in_ready}, 0);
`ifdef CELL_SEQ_STATS_EN
        check("stat_pixels", 64'(stat_pixels), 64'((W-2)*(H-2)));
        check("stat_stalls", 64'(stat_stalls), 64'(stalls));
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        tick();
        in_valid = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 0);
        in_valid = 1'b0;
        tick();
        run_frame(0, 4'd0, 8'd4, 0, 1, -1, 1'b0);
        run_frame(0, 4'd0, 8'd4, 0, 0, -1, 1'b0);
        run_frame(1, 4'd3, 8'($urandom), 1, 2, -1, 1'b0);
        run_frame(1, 4'd7, 8'($urandom), 1, 2, -1, 1'b1);
        run_frame(0, 4'd0, 8'd4, 0, 1, 7, 1'b0);
        run_frame(0, 4'd0, 8'd4, 0, 1, -1, 1'b0);
        for (int f = 0; f < 4; f++) begin
            run_frame(1, 4'($urandom), 8'($urandom), 1, 2, -1, 1'b0);
        end
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
